// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the data-memory access controller:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD)
//   - controller state enum mac_state_t
//   - legal bounds of the read-latency parameter and the wait-counter width
//   - helpers: size normalisation and misalignment detection
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = 3;   // holds RD_LAT_MAX

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } mac_state_t;

    // The reserved encoding behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == SZ_RSVD) ? SZ_WORD : size;
    endfunction

    // Halfwords need addr[0] clear; words (and reserved) need addr[1:0] clear.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_HALF) && off[0]) || (size[1] && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// -----------------------------------------------------------------------------
// mem_lane_unit
// Purely combinational little-endian byte-lane logic.
// Ports:
//   size       in  2   normalised access size (never SZ_RSVD)
//   sign_ext   in  1   1 = sign-extend sub-word loads, 0 = zero-extend
//   offset     in  2   byte offset addr[1:0]
//   word       in  32  word captured from memory
//   wdata      in  32  right-justified store data
//   load_data  out 32  extracted and extended load result
//   store_word out 32  memory word with addressed lane(s) replaced
// Halfword lanes use offset[1] only; word accesses ignore the offset.
// -----------------------------------------------------------------------------
module mem_lane_unit
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    function automatic logic [31:0] extract(input logic [1:0]  sz,
                                            input logic        sx,
                                            input logic [1:0]  off,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        // NOTE: every local gets a value on every path before use, so the
        // combinational result never has to remember an old value (no latch).
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        r = w;
        case (sz)
            SZ_BYTE: r = {{24{sx & b[7]}}, b};
            SZ_HALF: r = {{16{sx & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [1:0]  sz,
                                          input logic [1:0]  off,
                                          input logic [31:0] w,
                                          input logic [31:0] d);
        logic [31:0] m;
        m = w;
        case (sz)
            SZ_BYTE: m[{off, 3'b000} +: 8] = d[7:0];
            SZ_HALF: begin
                if (off[1]) m[31:16] = d[15:0];
                else        m[15:0]  = d[15:0];
            end
            default: m = d;
        endcase
        return m;
    endfunction

    assign load_data  = extract(size, sign_ext, offset, word);
    assign store_word = merge(size, offset, word, wdata);

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Multi-cycle controller between the CPU MEM stage and a word-only synchronous
// data RAM. Sequences byte/half/word loads (lane extract + sign/zero extend)
// and stores (sub-word stores as read-modify-write).
// Parameter:
//   RD_LAT     cycles from the mem_rd cycle to mem_rdata valid (1..4)
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req, we, size     access request (sampled in IDLE only), store flag, size
//   sign_ext          sub-word load extension select
//   addr, wdata       byte address, right-justified store data
//   busy, done        controller active, one-cycle completion pulse
//   rdata             load result, held until the next load completes
//   addr_err          one-cycle misalignment pulse (alongside done)
//   mem_addr          word address addr[31:2]
//   mem_rd, mem_wr    one-cycle read / write strobes
//   mem_wdata         write word
//   mem_rdata         read word from RAM
// Build option:
//   MEM_ALIGN_CHECK_EN  when defined, misaligned halfword/word requests go
//                       straight to DONE with addr_err and no memory strobe;
//                       otherwise offending low address bits are ignored and
//                       addr_err is tied low.
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic [29:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Out-of-range latencies are clamped to the supported window.
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mac_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [1:0]       size_q;     // normalised, never SZ_RSVD
    logic             sx_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      data_q;     // word captured from the RAM
    logic [31:0]      rdata_q;
    logic             err_q;      // current access was rejected as misaligned

    logic             misaligned;
    logic             load_done;
    logic [31:0]      load_data;
    logic [31:0]      store_word;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(size, addr[1:0]);
    assign addr_err   = (state == ST_DONE) && err_q;
`else
    assign misaligned = 1'b0;
    assign addr_err   = 1'b0;
`endif

    mem_lane_unit u_lane (
        .size       (size_q),
        .sign_ext   (sx_q),
        .offset     (addr_q[1:0]),
        .word       (data_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout the clocked block so every
        // register samples the values present before the edge.
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sx_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= norm_size(size);
                        sx_q    <= sign_ext;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        err_q   <= misaligned;
                        if (misaligned)
                            state <= ST_DONE;
                        else if (we && (norm_size(size) == SZ_WORD))
                            state <= ST_WRITE;   // full word: no read needed
                        else
                            state <= ST_READ;
                    end
                end
                ST_READ: begin
                    cnt   <= LAT_CNT;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    // Count of one means mem_rdata is valid in this cycle.
                    if (cnt == CNT_ONE) begin
                        data_q <= mem_rdata;
                        state  <= we_q ? ST_WRITE : ST_DONE;
                    end
                end
                ST_WRITE: state <= ST_DONE;
                ST_DONE: begin
                    if (load_done) rdata_q <= load_data;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign mem_rd    = (state == ST_READ);
    // WRITE decodes combinationally; gating with rst stops a partial write.
    assign mem_wr    = (state == ST_WRITE) && !rst;
    assign mem_addr  = addr_q[31:2];
    assign mem_wdata = store_word;

    // The result is presented in the DONE cycle itself and held afterwards.
    assign load_done = done && !we_q && !err_q;
    assign rdata     = load_done ? load_data : rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Two controller instances (RD_LAT = 1 and RD_LAT = 3), each with its own
// word RAM model whose read data is only valid RD_LAT cycles after mem_rd.
// Expected results come from a byte-array memory model.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_init = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic        req       [NI];
    logic        busy      [NI];
    logic        done      [NI];
    logic        addr_err  [NI];
    logic        mem_rd    [NI];
    logic        mem_wr    [NI];
    logic [31:0] rdata     [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata [NI];
    logic [29:0] mem_addr  [NI];

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] x;
        x = 32'(i + 1) * 32'h9E37_79B9;
        return (i == 16) ? 32'h80FF_7F01 : (x ^ 32'h0F0F_1234);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] ram  [64];
        logic [31:0] pipe [L];

        mem_access_ctrl #(.RD_LAT(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req       (req[g]),
            .we        (we),
            .size      (size),
            .sign_ext  (sign_ext),
            .addr      (addr),
            .wdata     (wdata),
            .busy      (busy[g]),
            .done      (done[g]),
            .rdata     (rdata[g]),
            .addr_err  (addr_err[g]),
            .mem_addr  (mem_addr[g]),
            .mem_rd    (mem_rd[g]),
            .mem_wr    (mem_wr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );

        // Data is garbage except exactly L cycles after a read strobe.
        always @(posedge clk) begin
            if (ram_init) begin
                for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            end else if (mem_wr[g]) begin
                ram[mem_addr[g][5:0]] <= mem_wdata[g];
            end
            pipe[0] <= mem_rd[g] ? ram[mem_addr[g][5:0]] : 32'h5A5A_C3C3;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[L-1];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem   [NI][256];
    logic [31:0] last_load [NI];

    task automatic ref_reset(input int k);
        logic [31:0] w;
        for (int a = 0; a < 256; a++) begin
            w = init_word(a / 4);
            ref_mem[k][a] = w[8*(a%4) +: 8];
        end
    endtask

    task automatic model(input int k, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rv, output int nrd,
                         output int nwr, output logic [31:0] ww, output logic err);
        int esz, nb, off, base, lat_rd;
        logic mis;
        logic [31:0] val;
        esz    = (sz == 2'b11) ? 2 : int'(sz);
        nb     = 1 << esz;
        off    = (esz == 0) ? int'(a[1:0]) : (esz == 1) ? (a[1] ? 2 : 0) : 0;
        base   = int'(a[7:0]) & ~3;
        lat_rd = (k == 0) ? 1 : 3;
        mis    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = ((esz == 1) && a[0]) || ((esz == 2) && (a[1:0] != 2'b00));
`endif
        ww  = '0;
        err = mis;
        if (mis) begin
            lat = 1; nrd = 0; nwr = 0; rv = last_load[k];
        end else if (w) begin
            for (int b = 0; b < nb; b++) ref_mem[k][base+off+b] = wd[8*b +: 8];
            ww  = {ref_mem[k][base+3], ref_mem[k][base+2], ref_mem[k][base+1], ref_mem[k][base]};
            nwr = 1;
            nrd = (esz == 2) ? 0 : 1;
            lat = (esz == 2) ? 2 : 3 + lat_rd;
            rv  = last_load[k];
        end else begin
            val = '0;
            for (int b = 0; b < nb; b++) val = val | (32'(ref_mem[k][base+off+b]) << (8*b));
            if (sx && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8*nb)) - 32'd1);
            lat = 2 + lat_rd; nrd = 1; nwr = 0;
            last_load[k] = val;
            rv = val;
        end
    endtask

    // Issue one access starting at a falling edge with the DUT idle; returns
    // one falling edge after done (the earliest cycle a new req is accepted).
    task automatic do_access(input int k, input logic w, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output logic [31:0] rv, output int nrd,
                             output int nwr, output logic [31:0] ww, output logic err,
                             output int bad);
        int start;
        we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req[k] = 1'b1;
        start = cyc; lat = -1; rv = '0; nrd = 0; nwr = 0; ww = '0; err = 1'b0; bad = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            req[k] = 1'b0;
            if (!busy[k]) bad++;
            if (mem_rd[k] && mem_wr[k]) bad++;
            if ((mem_rd[k] || mem_wr[k]) && (mem_addr[k] != a[31:2])) bad++;
            if (mem_rd[k]) nrd++;
            if (mem_wr[k]) begin nwr++; ww = mem_wdata[k]; end
            if (addr_err[k]) err = 1'b1;
            if (done[k]) begin lat = cyc - start; rv = rdata[k]; break; end
        end
        req[k] = 1'b0;
        @(negedge clk);
        if (done[k] || busy[k] || addr_err[k]) bad++;
    endtask

    task automatic run_chk(input string tag, input int k, input logic w, input logic [1:0] sz,
                           input logic sx, input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rv, output logic [31:0] ww);
        int nrd, nwr, bad, e_lat, e_nrd, e_nwr;
        logic [31:0] e_rv, e_ww;
        logic err, e_err;
        do_access(k, w, sz, sx, a, wd, lat, rv, nrd, nwr, ww, err, bad);
        model(k, w, sz, sx, a, wd, e_lat, e_rv, e_nrd, e_nwr, e_ww, e_err);
        check({tag, "_lat"},   32'(lat),  32'(e_lat));
        check({tag, "_rdata"}, rv,        e_rv);
        check({tag, "_nrd"},   32'(nrd),  32'(e_nrd));
        check({tag, "_nwr"},   32'(nwr),  32'(e_nwr));
        check({tag, "_err"},   32'(err),  32'(e_err));
        check({tag, "_proto"}, 32'(bad),  32'd0);
        if (e_nwr != 0) check({tag, "_wdata"}, ww, e_ww);
    endtask

    // ---------------- directed vectors (instance with RD_LAT = 1) ----------------
    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rv;
        logic [31:0] ww;
    } vec_t;

    vec_t tbl [14];

    initial begin : main
        int lat, lat2, t0, s2;
        logic [31:0] rv, ww;

        tbl[0]  = '{1'b0, SZ_BYTE, 1'b1, 32'h43, 32'h0,         3, 32'hFFFF_FF80, 32'h0};
        tbl[1]  = '{1'b0, SZ_BYTE, 1'b0, 32'h43, 32'h0,         3, 32'h0000_0080, 32'h0};
        tbl[2]  = '{1'b0, SZ_HALF, 1'b1, 32'h42, 32'h0,         3, 32'hFFFF_80FF, 32'h0};
        tbl[3]  = '{1'b0, SZ_HALF, 1'b0, 32'h42, 32'h0,         3, 32'h0000_80FF, 32'h0};
        tbl[4]  = '{1'b0, SZ_BYTE, 1'b1, 32'h41, 32'h0,         3, 32'h0000_007F, 32'h0};
        tbl[5]  = '{1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0,         3, 32'h80FF_7F01, 32'h0};
        tbl[6]  = '{1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h0000_00AB, 4, 32'h80FF_7F01, 32'h80FF_AB01};
        tbl[7]  = '{1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0,         3, 32'h80FF_AB01, 32'h0};
        tbl[8]  = '{1'b1, SZ_WORD, 1'b0, 32'h40, 32'h1234_5678, 2, 32'h80FF_AB01, 32'h1234_5678};
        tbl[9]  = '{1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0,         3, 32'h1234_5678, 32'h0};
        tbl[10] = '{1'b1, SZ_HALF, 1'b0, 32'h42, 32'hDEAD_BEEF, 4, 32'h1234_5678, 32'hBEEF_5678};
`ifdef MEM_ALIGN_CHECK_EN
        tbl[11] = '{1'b0, SZ_HALF, 1'b1, 32'h41, 32'h0,         1, 32'h1234_5678, 32'h0};
`else
        tbl[11] = '{1'b0, SZ_HALF, 1'b1, 32'h41, 32'h0,         3, 32'h0000_5678, 32'h0};
`endif
        tbl[12] = '{1'b0, SZ_RSVD, 1'b0, 32'h40, 32'h0,         3, 32'hBEEF_5678, 32'h0};
        tbl[13] = '{1'b0, SZ_BYTE, 1'b1, 32'h42, 32'h0,         3, 32'hFFFF_FFEF, 32'h0};

        for (int k = 0; k < NI; k++) req[k] = 1'b0;
        we = 1'b0; size = SZ_BYTE; sign_ext = 1'b0; addr = '0; wdata = '0;
        rst = 1'b1; ram_init = 1'b1;
        repeat (3) @(negedge clk);
        ram_init = 1'b0;

        // Reset values.
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst%0d_busy", k),      32'(busy[k]),      32'd0);
            check($sformatf("rst%0d_done", k),      32'(done[k]),      32'd0);
            check($sformatf("rst%0d_addr_err", k),  32'(addr_err[k]),  32'd0);
            check($sformatf("rst%0d_mem_rd", k),    32'(mem_rd[k]),    32'd0);
            check($sformatf("rst%0d_mem_wr", k),    32'(mem_wr[k]),    32'd0);
            check($sformatf("rst%0d_rdata", k),     rdata[k],          32'd0);
            check($sformatf("rst%0d_mem_wdata", k), mem_wdata[k],      32'd0);
            check($sformatf("rst%0d_mem_addr", k),  32'(mem_addr[k]), 32'd0);
            ref_reset(k);
            last_load[k] = '0;
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            run_chk($sformatf("vec%0d", i), 0, tbl[i].w, tbl[i].sz, tbl[i].sx, tbl[i].a,
                    tbl[i].wd, lat, rv, ww);
            check($sformatf("vec%0d_tbl_lat", i),   32'(lat), 32'(tbl[i].lat));
            check($sformatf("vec%0d_tbl_rdata", i), rv,       tbl[i].rv);
            if (tbl[i].w) check($sformatf("vec%0d_tbl_wdata", i), ww, tbl[i].ww);
        end

        // Reset while waiting for read data during a byte store.
        we = 1'b1; size = SZ_BYTE; sign_ext = 1'b0; addr = 32'h44; wdata = 32'h55; req[0] = 1'b1;
        @(negedge clk);                       // READ
        req[0] = 1'b0;
        check("rstwait_rd", 32'(mem_rd[0]), 32'd1);
        @(negedge clk);                       // WAIT
        rst = 1'b1;
        #1 check("rstwait_wr_wait", 32'(mem_wr[0]), 32'd0);
        @(negedge clk);                       // after reset edge
        check("rstwait_wr",     32'(mem_wr[0]),    32'd0);
        check("rstwait_rd0",    32'(mem_rd[0]),    32'd0);
        check("rstwait_busy",   32'(busy[0]),      32'd0);
        check("rstwait_done",   32'(done[0]),      32'd0);
        check("rstwait_err",    32'(addr_err[0]),  32'd0);
        check("rstwait_rdata",  rdata[0],          32'd0);
        check("rstwait_addr",   32'(mem_addr[0]), 32'd0);
        check("rstwait_wdata",  mem_wdata[0],      32'd0);
        rst = 1'b0;
        last_load[0] = '0;
        last_load[1] = '0;
        @(negedge clk);

        // Reset coinciding with WRITE must suppress the strobe.
        we = 1'b1; size = SZ_BYTE; sign_ext = 1'b0; addr = 32'h44; wdata = 32'h66; req[0] = 1'b1;
        @(negedge clk);                       // READ
        req[0] = 1'b0;
        @(negedge clk);                       // WAIT
        @(negedge clk);                       // WRITE
        check("rstwr_pre_wr", 32'(mem_wr[0]), 32'd1);
        rst = 1'b1;
        #1 check("rstwr_gated", 32'(mem_wr[0]), 32'd0);
        @(negedge clk);
        check("rstwr_busy", 32'(busy[0]), 32'd0);
        check("rstwr_done", 32'(done[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        // Word 0x11 must be unchanged (model was not updated by the aborted stores).
        run_chk("rstwr_readback", 0, 1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0, lat, rv, ww);

        // Back-to-back loads on the RD_LAT = 3 instance.
        t0 = cyc;
        run_chk("b2b_a", 1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, lat, rv, ww);
        s2 = cyc;
        run_chk("b2b_b", 1, 1'b0, SZ_BYTE, 1'b1, 32'h43, 32'h0, lat2, rv, ww);
        check("b2b_done1", 32'(lat), 32'd5);
        check("b2b_done2", 32'((s2 - t0) + lat2), 32'd11);
        check("b2b_rdata2", rv, 32'hFFFF_FF80);

        // Randomized accesses on both instances.
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 150; i++) begin
                run_chk($sformatf("rnd%0d_%0d", k, i), k, 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        32'($urandom_range(0, 255)), $urandom, lat, rv, ww);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle data-memory access controller between the CPU's MEM stage and a word-only synchronous data RAM. It sequences word, halfword and byte loads and stores, performing byte-lane extraction with sign or zero extension on loads and read-modify-write merging on sub-word stores. The CPU stalls on `busy` and consumes the result on `done`.

## Interface
- `RD_LAT`, default 1: cycles from the `mem_rd` cycle to `mem_rdata` valid; legal range is 1..4.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  access request; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- `sign_ext`  in  1  for sub-word loads: 1 sign-extends, 0 zero-extends.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-justified.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load result; holds until the next load completes.
- `addr_err`  out  1  one-cycle misalignment pulse (macro-dependent).
- `mem_addr`  out  30  word address, `addr[31:2]`.
- `mem_rd`  out  1  one-cycle read strobe.
- `mem_wr`  out  1  one-cycle write strobe.
- `mem_wdata`  out  32  write word.
- `mem_rdata`  in  32  read word.

## Operation
- **Little-endian lanes.** `addr[1:0]` selects the lane: 00 → [7:0], 01 → [15:8], 10 → [23:16], 11 → [31:24]. Halfword lanes: `addr[1]` = 0 → [15:0], 1 → [31:16].
- **States:** IDLE, READ, WAIT, WRITE, DONE.
- **IDLE.** On `req`, latch `we`, `size`, `sign_ext`, `addr` and `wdata`.
  - Word store → WRITE.
  - Otherwise → READ.
- **READ.** `mem_rd` = 1. Load the wait counter with `RD_LAT`. → WAIT.
- **WAIT.** Decrement the counter. In the cycle the counter reaches its last count, capture `mem_rdata` into the data register.
  - Load → DONE; `rdata` is extracted and extended from the captured word.
  - Sub-word store → WRITE.
- **WRITE.** `mem_wr` = 1.
  - Sub-word store: `mem_wdata` is the captured word with the addressed lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`.
  - Word store: `mem_wdata` = `wdata`.
  - → DONE.
- **DONE.** `done` = 1. → IDLE.
- **Requests while busy.** `req` is ignored while `busy` = 1. The CPU must not present a new request until `busy` is low.
- **Idle memory outputs.** `mem_addr` and `mem_wdata` are don't-care when the strobes are low. `mem_rd` and `mem_wr` are never high in the same cycle.

## Timing
- **Reset values.** State = IDLE; `busy`, `done`, `addr_err`, `mem_rd`, `mem_wr` = 0; `rdata`, `mem_wdata`, `mem_addr` = 0.
- **Latency.** Request accepted at cycle 0; `done` occurs at:
  - word store: cycle 2;
  - load: cycle 2 + `RD_LAT`;
  - sub-word store: cycle 3 + `RD_LAT`.
- **Busy window.** `busy` is high from cycle 1 through the DONE cycle, inclusive.
- **Back-to-back accesses.** A new `req` can be accepted in the cycle after DONE.
- **Reset mid-operation.** The next edge returns to IDLE and clears the strobes. No partial write is issued after reset: a WRITE state coinciding with `rst` still drives `mem_wr` combinationally, so `mem_wr` is gated with `!rst`.

## Configuration
- **With `MEM_ALIGN_CHECK_EN` defined:**
  - Halfword with `addr[0]` = 1, or word/reserved with `addr[1:0]` ≠ 00, is misaligned.
  - In the accept cycle the controller goes to DONE directly, with no memory strobe.
  - `addr_err` and `done` pulse together at cycle 1, and `rdata` is unchanged.
- **Without it:**
  - Offending low address bits are ignored: half uses `addr[1]` only; word forces the lane to 00.
  - `addr_err` is tied to 0.

## Structure
- **Package `mem_ctrl_pkg`:**
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - state enum `mac_state_t`;
  - `RD_LAT` bounds.
- **Sub-module `mem_lane_unit`:** purely combinational lane logic, with load extract/extend and store merge functions. It is instantiated once, fed by the latched request and the captured word.
- **Top level:** contains the FSM, wait counter and registers.

## Test plan
- **Load byte, signed.** Preload word 0x0000_0010 = 0x80FF_7F01, `RD_LAT` = 1. Issue lb at addr 0x43 with `sign_ext` = 1 → `done` at cycle 3, `rdata` = 0xFFFF_FF80. Same access with `sign_ext` = 0 → 0x0000_0080.
- **Load halfword.** Load half from addr 0x42, signed → `rdata` = 0xFFFF_80FF.
- **Store byte (read-modify-write).** Store byte 0xAB to 0x41 → exactly one `mem_rd`, then one `mem_wr` with `mem_wdata` = 0x80FF_AB01; `done` at cycle 4.
- **Store word.** Store word 0x1234_5678 to 0x40 → no `mem_rd`; `mem_wr` at cycle 1, `done` at cycle 2. Reading back returns 0x1234_5678.
- **Misaligned half.** Half load at 0x41 → with `MEM_ALIGN_CHECK_EN`: `addr_err` and `done` at cycle 1, no strobes. Without the macro: `rdata` = lane [15:0], sign-extended.
- **Reset and back-to-back.** Assert `rst` while in WAIT during a sub-word store → no `mem_wr` occurs, all outputs read 0 next cycle. Then issue two back-to-back loads with `RD_LAT` = 3 → `done` at cycles 5 and 11.
